// File: rtl/ysyx_22050019_axil_rd_slave.sv
// AXI4-Lite read-only slave that bridges a single outstanding read onto a
// simple synchronous memory port. Word-aligned requests are forwarded to
// memory after a configurable number of wait cycles. Misaligned requests
// are answered immediately with SLVERR and never touch memory.
module ysyx_22050019_axil_rd_slave #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] araddr,
    input  logic          arvalid,
    output logic          arready,
    output logic [DW-1:0] rdata,
    output logic [1:0]    rresp,
    output logic          rvalid,
    input  logic          rready,
    output logic          mem_ren,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] LAT_C       = 4'(LAT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t        state_r;
    logic [3:0]    cnt_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] rdata_r;
    logic [1:0]    rresp_r;
    logic          arready_r;
    logic          rvalid_r;
    logic          mem_ren_r;

    // Low two address bits decide between a memory access and an error reply.
    logic          aligned_s;
    assign aligned_s = (araddr[1:0] == 2'b00);

    assign arready  = arready_r;
    assign rvalid   = rvalid_r;
    assign mem_ren  = mem_ren_r;
    assign mem_addr = addr_r;
    assign rdata    = rdata_r;
    assign rresp    = rresp_r;

    // Read FSM: state, wait counter, address/data registers and the
    // handshake outputs all move together so every output is registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            addr_r    <= {AW{1'b0}};
            rdata_r   <= {DW{1'b0}};
            rresp_r   <= RESP_OKAY;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            mem_ren_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arvalid) begin
                        addr_r    <= araddr;
                        arready_r <= 1'b0;
                        if (aligned_s) begin
                            state_r   <= ST_WAIT;
                            cnt_r     <= LAT_C;
                            mem_ren_r <= 1'b1;
                        end else begin
                            // Misaligned: answer at once, memory stays idle.
                            state_r  <= ST_RESP;
                            rdata_r  <= {DW{1'b0}};
                            rresp_r  <= RESP_SLVERR;
                            rvalid_r <= 1'b1;
                        end
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        // Only sample point of mem_rdata.
                        rdata_r   <= mem_rdata;
                        rresp_r   <= RESP_OKAY;
                        state_r   <= ST_RESP;
                        mem_ren_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rready) begin
                        state_r   <= ST_IDLE;
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                    end else begin
                        rvalid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 4'd0;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                    mem_ren_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ysyx_22050019_axil_rd_slave.md
YSYX_22050019_AXIL_RD_SLAVE -- requirements
Module: ysyx_22050019_axil_rd_slave

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; the only supported value is 32.
REQ-003 SHALL have parameter LAT, default 2, extra memory wait cycles; range 0..15.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port araddr, input, AW, read address.
REQ-007 SHALL have port arvalid, input, 1, read-address valid.
REQ-008 SHALL have port arready, output, 1, read-address ready.
REQ-009 SHALL have port rdata, output, DW, read data.
REQ-010 SHALL have port rresp, output, 2, response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-011 SHALL have port rvalid, output, 1, read-data valid.
REQ-012 SHALL have port rready, input, 1, read-data ready.
REQ-013 SHALL have port mem_ren, output, 1, memory read enable.
REQ-014 SHALL have port mem_addr, output, AW, memory address; always equals the latched request address.
REQ-015 SHALL have port mem_rdata, input, DW, memory data; combinational from mem_addr while mem_ren=1.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive arready=1 only in IDLE; rvalid=1 only in RESP; mem_ren=1 only in WAIT.
REQ-018 SHALL treat an AR handshake as arvalid=1 and arready=1 at a rising edge; on it, SHALL latch araddr into the address register.
REQ-019 SHALL, on an AR handshake with araddr[1:0]==0, enter WAIT and load the wait counter with LAT.
REQ-020 SHALL, in WAIT with counter>0, decrement the counter each cycle.
REQ-021 SHALL, in WAIT with counter==0, capture mem_rdata into rdata, set rresp=2'b00, and enter RESP.
REQ-022 SHALL give latency as: handshake at edge k -> rvalid first high after edge k+LAT+1; with LAT=0, mem_ren is high for exactly one cycle.
REQ-023 SHALL, on an AR handshake with araddr[1:0]!=0, go directly to RESP with rdata=0 and rresp=2'b10; mem_ren never asserts for that request.
REQ-024 SHALL hold rdata, rresp and rvalid stable in RESP until rready=1 at an edge, then return to IDLE.
REQ-025 SHALL NOT accept a new AR while in WAIT or RESP; at most one outstanding read.
REQ-026 SHALL, after an R handshake, accept the next AR no earlier than the following edge, because arready rises in IDLE.
REQ-027 SHALL ignore mem_rdata in every cycle except WAIT with counter==0.
REQ-028 SHALL ignore araddr whenever arvalid=0; the address register SHALL change only on an AR handshake.

Reset
REQ-029 SHALL, at an edge with rst_n=0, set state=IDLE, counter=0, address register=0, rdata=0, rresp=2'b00; the outputs are then arready=1, rvalid=0, mem_ren=0, mem_addr=0.
REQ-030 SHALL, on reset asserted in WAIT or RESP, abandon the transaction: no R beat is issued, and mem_ren=0 from the next cycle.
REQ-031 SHALL give reset priority over any simultaneous handshake.

Verification
REQ-032 SHALL cover: LAT=2, araddr=0x8000_0000 with mem returning 0xDEAD_BEEF, rready=1 -> rvalid high 3 cycles after the AR edge, rdata=0xDEAD_BEEF, rresp=00, mem_ren high 3 cycles.
REQ-033 SHALL cover: LAT=0 -> mem_ren high 1 cycle; rvalid high after the next edge.
REQ-034 SHALL cover: araddr=0x8000_0002 -> rresp=10 and rdata=0 one edge later; mem_ren stays 0.
REQ-035 SHALL cover: rready held 0 for 5 cycles in RESP -> rvalid, rdata and rresp stable; arready=0 throughout; a new arvalid is ignored.
REQ-036 SHALL cover: back-to-back reads 0x0 then 0x4 with rready=1 -> the second AR is accepted the cycle after the first R handshake, and the data is correct and in order.
REQ-037 SHALL cover: rst_n=0 asserted mid-WAIT -> next cycle arready=1, rvalid=0, mem_ren=0, and no stale R beat appears.
